prog_ctrl: RTL
==============

PROG_CTRL -- requirements
Module: prog_ctrl

Interface
REQ-001 Parameter IMEM_SZ, default 16: number of instruction words loaded per program.
REQ-002 Parameter ADDR_W, default 4: instruction address width; IMEM_SZ SHALL equal 2**ADDR_W.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_req, run_req, step_req, halt_req  in  1 each  single-cycle command pulses.
REQ-006 ld_valid  in  1  loader byte valid.
REQ-007 ld_data  in  8  loader byte, one instruction word.
REQ-008 ld_ready  out  1  loader byte accepted when ld_valid and ld_ready are both high.
REQ-009 pc_end  in  1  core PC equals IMEM_SZ-1.
REQ-010 imem_we, imem_waddr[ADDR_W-1:0], imem_wdata[7:0]  out  instruction-memory write port.
REQ-011 cpu_en  out  1  core advance enable for pc, acc and dmem.
REQ-012 cpu_rst  out  1  core pc/acc/dmem synchronous reset; it SHALL NOT reinitialise imem.
REQ-013 done  out  1  program-finished pulse.
REQ-014 state  out  3  FSM state encoding.
REQ-015 cyc_cnt  out  16  count of enabled core cycles.

Function
REQ-016 FSM states and encodings: IDLE=0, LOAD=1, CLR=2, RUN=3, STEP=4, HALT=5; encodings 6-7 SHALL return to IDLE on the next edge.
REQ-017 Command priority when pulses coincide: load_req > halt_req > run_req > step_req; a pulse not legal in the current state is dropped, with no queuing.
REQ-018 IDLE transitions:
  - load_req -> LOAD, with write address counter set to 0.
  - run_req -> CLR, with next-target RUN.
REQ-019 LOAD behaviour:
  - ld_ready=1 for the whole state.
  - Each accepted byte: imem_we=1 for exactly one cycle, in the cycle after acceptance, with imem_waddr = counter and imem_wdata = byte.
  - Counter then increments.
REQ-020 Acceptance of byte IMEM_SZ-1: next state CLR with next-target HALT; the counter wraps to 0.
REQ-021 halt_req in LOAD aborts to IDLE; bytes already written remain; a pending imem_we still completes.
REQ-022 load_req in LOAD restarts at address 0.
REQ-023 CLR lasts exactly one cycle:
  - cpu_rst=1, cpu_en=0.
  - cyc_cnt cleared to 0.
  - Next state is the stored next-target.
REQ-024 RUN behaviour:
  - cpu_en=1 every cycle.
  - halt_req or pc_end -> HALT; cpu_en is low from the cycle after the event is sampled.
REQ-025 done pulses high for one cycle, in the cycle after pc_end is sampled in RUN or STEP; halt_req coincident with pc_end still yields done.
REQ-026 HALT transitions:
  - run_req -> RUN, resuming without cpu_rst.
  - step_req -> STEP.
  - load_req -> LOAD.
REQ-027 STEP lasts exactly one cycle with cpu_en=1, then returns to HALT; pc_end sampled in STEP asserts done.
REQ-028 cyc_cnt increments by 1 on each cycle with cpu_en=1 and saturates at 16'hFFFF.
REQ-029 cpu_en = (state==RUN) or (state==STEP), decoded from the state register only; outputs SHALL NOT combinationally depend on request inputs.
REQ-030 ld_ready=0 in every state except LOAD; ld_valid outside LOAD is ignored.

Reset
REQ-031 rst high on an edge, including mid-LOAD or mid-RUN, forces the following outputs:
  - state=IDLE; write address counter=0; next-target=HALT.
  - ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - cpu_en=0, cpu_rst=0, done=0, cyc_cnt=0.
REQ-032 A write accepted in the cycle rst is asserted SHALL NOT reach imem_we.

Verification
REQ-033 Load sequence: load_req, then 16 bytes 8'h00..8'h0F with continuous ld_valid -> 16 single-cycle writes with addr=data 0..15, then one cpu_rst cycle, then state=HALT.
REQ-034 Run to end: run_req in HALT with pc_end raised 5 cycles later -> cpu_en high exactly 5 cycles, done one pulse, cyc_cnt=5, state=HALT.
REQ-035 Single step: 3 step_req pulses spaced 4 cycles apart in HALT -> exactly 3 one-cycle cpu_en pulses, cyc_cnt=3.
REQ-036 Load abort and gaps: halt_req after 7 bytes with ld_valid gapped -> 7 writes to addr 0..6, state=IDLE; a following load_req restarts at addr 0.
REQ-037 Command collisions:
  - load_req+run_req coincident in HALT -> LOAD.
  - halt_req+pc_end coincident in RUN -> HALT, done=1 once.
REQ-038 Reset mid-RUN: rst at cyc_cnt=9 -> all outputs at REQ-031 values on the next cycle; run_req afterward -> CLR then RUN with cyc_cnt starting from 0.

Source files
------------

// File: rtl/prog_ctrl_if.sv
// Loader byte handshake and instruction-memory write port of the program controller.
interface prog_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [7:0]        imem_wdata;

    modport master (
        output ld_valid, ld_data,
        input  ld_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  ld_valid, ld_data,
        output ld_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/prog_ctrl.sv
// Program controller: loads instruction memory byte-wise, then runs, steps or halts the core.
// IMEM_SZ must equal 2**ADDR_W.
//   state | meaning
//   IDLE  | nothing loaded or load aborted, core held
//   LOAD  | accepting loader bytes into imem
//   CLR   | one-cycle core reset, then jump to stored target
//   RUN   | core free-running
//   STEP  | single enabled core cycle
//   HALT  | core paused, program resident
module prog_ctrl #(
    parameter int IMEM_SZ = 16,
    parameter int ADDR_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        pc_end,
    prog_ctrl_if.slave  ld,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic        done,
    output logic [2:0]  state,
    output logic [15:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CLR  = 3'd2,
        S_RUN  = 3'd3,
        S_STEP = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              tgt_run_q, tgt_run_d;
    logic              accept;
    logic              last_byte;

    assign accept    = ld.ld_valid && (state_q == S_LOAD);
    assign last_byte = (wcnt_q == ADDR_W'(IMEM_SZ - 1));
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tgt_run_d = tgt_run_q;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end else if (run_req) begin
                    state_d   = S_CLR;
                    tgt_run_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) wcnt_d = last_byte ? '0 : wcnt_q + 1'b1;
                // an accepted byte is always written; a restart only rewinds the counter
                if (load_req) begin
                    wcnt_d = '0;
                end else if (halt_req) begin
                    state_d = S_IDLE;
                end else if (accept && last_byte) begin
                    state_d   = S_CLR;
                    tgt_run_d = 1'b0;
                end
            end
            S_CLR:  state_d = tgt_run_q ? S_RUN : S_HALT;
            S_RUN:  if (halt_req || pc_end) state_d = S_HALT;
            S_STEP: state_d = S_HALT;
            S_HALT: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end else if (run_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld.ld_ready = (state_q == S_LOAD);
        cpu_en      = (state_q == S_RUN) || (state_q == S_STEP);
        cpu_rst     = (state_q == S_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q        <= '0;
            tgt_run_q     <= 1'b0;
            ld.imem_we    <= 1'b0;
            ld.imem_waddr <= '0;
            ld.imem_wdata <= '0;
            done          <= 1'b0;
            cyc_cnt       <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            tgt_run_q  <= tgt_run_d;
            ld.imem_we <= accept;
            if (accept) begin
                ld.imem_waddr <= wcnt_q;
                ld.imem_wdata <= ld.ld_data;
            end
            done <= cpu_en && pc_end;
            if (cpu_rst)
                cyc_cnt <= '0;
            else if (cpu_en && (cyc_cnt != 16'hFFFF))
                cyc_cnt <= cyc_cnt + 16'd1;
        end
    end

endmodule
